// File: rtl/flash_sequencer.sv
// flash_sequencer
// Drives the scoreboard flash timer to blank/unblank the display a latched
// number of times. Each dark or lit phase issues one timer_start pulse and
// waits for the timer's one-cycle timer_done. A per-phase watchdog returns to
// IDLE with a sticky fault if the timer stalls, and abort cancels a sequence.
//
// Ports
//   CLK_50MHZ   in   system clock, rising edge
//   RST         in   synchronous active-low reset
//   req         in   start request, sampled only in IDLE
//   blinks      in   dark+lit pair count, latched when req is accepted
//   abort       in   cancel a running sequence
//   timer_done  in   one-cycle done pulse from the flash timer
//   timer_start out  one-cycle start pulse to the flash timer
//   blank       out  1 = display forced dark
//   busy        out  1 in every state except IDLE
//   finished    out  one-cycle pulse on normal completion
//   fault       out  sticky watchdog-expiry flag
//
// state    | meaning
// ---------+---------------------------------------------
// IDLE     | waiting for req
// ARM_OFF  | start timer for the dark phase, display dark
// WAIT_OFF | dark phase running, waiting for timer_done
// ARM_ON   | start timer for the lit phase, display lit
// WAIT_ON  | lit phase running, waiting for timer_done
// DONE     | one-cycle completion pulse

module flash_sequencer #(
  parameter int CNT_W   = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic             CLK_50MHZ,
  input  logic             RST,
  input  logic             req,
  input  logic [CNT_W-1:0] blinks,
  input  logic             abort,
  input  logic             timer_done,
  output logic             timer_start,
  output logic             blank,
  output logic             busy,
  output logic             finished,
  output logic             fault
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ARM_OFF  = 3'd1;
  localparam logic [2:0] S_WAIT_OFF = 3'd2;
  localparam logic [2:0] S_ARM_ON   = 3'd3;
  localparam logic [2:0] S_WAIT_ON  = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  logic [CNT_W-1:0] r_n;
  logic [CNT_W-1:0] r_cnt;
  logic [WD_W-1:0]  r_wdog;
  logic             r_fault;

  logic             w_in_wait;
  logic             w_wd_expired;
  logic [CNT_W:0]   w_cnt_inc;
  logic             w_last;

  assign w_in_wait    = (r_state == S_WAIT_OFF) || (r_state == S_WAIT_ON);
  assign w_wd_expired = (r_wdog == WD_W'(TIMEOUT));
  // One extra bit so a full-scale count cannot wrap before the compare.
  assign w_cnt_inc    = {1'b0, r_cnt} + (CNT_W+1)'(1);
  assign w_last       = (w_cnt_inc == {1'b0, r_n});

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (req) begin
          if (blinks != '0) w_state_nxt = S_ARM_OFF;
          else              w_state_nxt = S_DONE;
        end
      end
      S_ARM_OFF: w_state_nxt = S_WAIT_OFF;
      S_WAIT_OFF: begin
        if (timer_done)        w_state_nxt = S_ARM_ON;
        else if (w_wd_expired) w_state_nxt = S_IDLE;
      end
      S_ARM_ON: w_state_nxt = S_WAIT_ON;
      S_WAIT_ON: begin
        if (timer_done)        w_state_nxt = w_last ? S_DONE : S_ARM_OFF;
        else if (w_wd_expired) w_state_nxt = S_IDLE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    // abort outranks every other transition
    if (abort && (r_state != S_IDLE)) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge CLK_50MHZ) begin
    if (!RST) begin
      r_state <= S_IDLE;
      r_n     <= '0;
      r_cnt   <= '0;
      r_wdog  <= '0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      if ((r_state == S_IDLE) && req) begin
        r_n     <= blinks;
        r_cnt   <= '0;
        r_fault <= 1'b0;
      end

      if ((r_state == S_WAIT_ON) && timer_done && !abort)
        r_cnt <= w_cnt_inc[CNT_W-1:0];

      // Counter is zero on the first WAIT cycle because ARM states clear it.
      if (w_in_wait && !timer_done && !w_wd_expired)
        r_wdog <= r_wdog + WD_W'(1);
      else
        r_wdog <= '0;

      if (w_in_wait && !timer_done && w_wd_expired && !abort)
        r_fault <= 1'b1;
    end
  end

  assign timer_start = (r_state == S_ARM_OFF) || (r_state == S_ARM_ON);
  assign blank       = (r_state == S_ARM_OFF) || (r_state == S_WAIT_OFF);
  assign busy        = (r_state != S_IDLE);
  assign finished    = (r_state == S_DONE);
  assign fault       = r_fault;

endmodule

// File: tb/tb_flash_sequencer.sv
// Testbench for flash_sequencer: table of directed sequences, hand-written
// reset/stall/ignored-input cases, and randomized sequences, all compared
// cycle by cycle against an arithmetic timeline model of the flash sequence.

module tb_flash_sequencer;
  localparam int CW = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req = 1'b0;
  logic          abort = 1'b0;
  logic          timer_done = 1'b0;
  logic [CW-1:0] blinks = '0;
  logic          timer_start, blank, busy, finished, fault;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int tmr_d = 0;
  int done_cycle = -1000;

  flash_sequencer #(.CNT_W(CW), .TIMEOUT(TO)) dut (
    .CLK_50MHZ  (clk),
    .RST        (rst_n),
    .req        (req),
    .blinks     (blinks),
    .abort      (abort),
    .timer_done (timer_done),
    .timer_start(timer_start),
    .blank      (blank),
    .busy       (busy),
    .finished   (finished),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    int n;
    int d;
    int ab;
    int starts;
    int fin_k;
    int idle_k;
    int flt;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [4:0] outs();
    return {timer_start, blank, busy, finished, fault};
  endfunction

  // First cycle (relative to the req cycle k=0) at which the block is idle again.
  function automatic int end_of(input int n, input int d, input int ab);
    int e;
    if (n == 0)      e = 2;
    else if (d > TO) e = TO + 3;
    else             e = 2 * n * (d + 2) + 2;
    if (ab > 0 && ab < e) e = ab + 1;
    return e;
  endfunction

  // Expected {timer_start, blank, busy, finished, fault} at cycle k.
  function automatic logic [4:0] model(input int n, input int d, input int ab, input int k);
    int  plen, e_norm, e, fin_k, p, o;
    bit  stall;
    plen  = d + 2;
    stall = (n != 0) && (d > TO);
    if (n == 0)     begin e_norm = 2;              fin_k = 1;          end
    else if (stall) begin e_norm = TO + 3;         fin_k = -1;         end
    else            begin e_norm = 2*n*plen + 2;   fin_k = e_norm - 1; end
    e = end_of(n, d, ab);
    if (e != e_norm) stall = 1'b0;
    if (k >= e)     return {4'b0000, stall};
    if (k == fin_k) return 5'b00110;
    p = (k - 1) / plen;
    o = (k - 1) % plen;
    return {(o == 0), ((p % 2) == 0), 1'b1, 1'b0, 1'b0};
  endfunction

  // Advance one cycle; outputs are then stable and inputs set now apply to
  // this cycle. The timer model answers D+1 cycles after each start.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (timer_start) done_cycle = cyc + tmr_d + 1;
    timer_done = (cyc == done_cycle);
  endtask

  task automatic run_seq(input int n, input int d, input int ab, input bit noisy,
                         input int inj_k, output int starts, output int fins,
                         output int fin_k, output int idle_k, output int flt);
    int e;
    e = end_of(n, d, ab);
    starts = 0; fins = 0; fin_k = -1; idle_k = -1;
    tmr_d = d; done_cycle = -1000; timer_done = 1'b0; abort = 1'b0;
    req = 1'b1; blinks = CW'(n);
    tick();
    for (int k = 1; k <= e + 1; k++) begin
      chk($sformatf("seq n=%0d d=%0d ab=%0d k=%0d outs", n, d, ab, k),
          outs(), model(n, d, ab, k));
      if (timer_start) starts++;
      if (finished) begin fins++; if (fin_k < 0) fin_k = k; end
      if (!busy && idle_k < 0) idle_k = k;
      abort = (k == ab);
      req = 1'b0;
      if (k == inj_k) begin
        req = 1'b1; blinks = CW'(5);
      end else if (noisy) begin
        blinks = CW'($urandom_range(0, 15));
        if (k < e && $urandom_range(0, 3) == 0) req = 1'b1;
      end
      tick();
    end
    flt = fault;
    abort = 1'b0; req = 1'b0; done_cycle = -1000; timer_done = 1'b0;
  endtask

  initial begin
    int st, fn, fk, ik, fl;
    int n, d, ab;

    vecs[0] = '{3,  8,  0,  6, 61, 62, 0};
    vecs[1] = '{0,  0,  0,  0,  1,  2, 0};
    vecs[2] = '{1,  0,  0,  2,  5,  6, 0};
    vecs[3] = '{15, 0,  0, 30, 61, 62, 0};
    vecs[4] = '{1,  16, 0,  2, 37, 38, 0};
    vecs[5] = '{2,  17, 0,  1, -1, 19, 1};
    vecs[6] = '{4,  3,  7,  2, -1,  8, 0};
    vecs[7] = '{2,  0,  2,  1, -1,  3, 0};
    vecs[8] = '{3,  5,  1,  1, -1,  2, 0};
    vecs[9] = '{2,  1, 13,  4, 13, 14, 0};

    // reset state
    rst_n = 1'b0;
    tick(); tick();
    chk("reset outs", outs(), 0);
    rst_n = 1'b1;
    tick();
    chk("after reset idle", outs(), 0);

    // directed table
    for (int i = 0; i < 10; i++) begin
      run_seq(vecs[i].n, vecs[i].d, vecs[i].ab, 1'b0, -1, st, fn, fk, ik, fl);
      chk($sformatf("row%0d starts", i), st, vecs[i].starts);
      chk($sformatf("row%0d finished cycle", i), fk, vecs[i].fin_k);
      chk($sformatf("row%0d idle cycle", i), ik, vecs[i].idle_k);
      chk($sformatf("row%0d fault", i), fl, vecs[i].flt);
      tick(); tick();
    end

    // ignored req during busy, then stray done in IDLE
    run_seq(2, 4, 0, 1'b0, 3, st, fn, fk, ik, fl);
    chk("ignored req starts", st, 4);
    chk("ignored req finished count", fn, 1);
    timer_done = 1'b1;
    tick();
    chk("stray done idle", outs(), 0);
    tick();
    chk("stray done idle 2", outs(), 0);

    // reset held for 3 cycles during WAIT_ON, req asserted meanwhile
    tmr_d = 8; done_cycle = -1000; timer_done = 1'b0;
    req = 1'b1; blinks = CW'(3);
    tick();
    req = 1'b0;
    repeat (11) tick();
    chk("rst hold pre WAIT_ON", outs(), 5'b00100);
    rst_n = 1'b0; req = 1'b1; blinks = CW'(2);
    for (int j = 0; j < 3; j++) begin
      tick();
      chk($sformatf("rst hold cycle %0d", j), outs(), 0);
    end
    rst_n = 1'b1; req = 1'b0; done_cycle = -1000;
    for (int j = 0; j < 2; j++) begin
      tick();
      chk($sformatf("rst release idle %0d", j), outs(), 0);
    end

    // stall: fault sticky, unaffected by abort in IDLE, cleared by reset
    run_seq(1, TO + 2, 0, 1'b0, -1, st, fn, fk, ik, fl);
    chk("stall fault", fl, 1);
    chk("stall no finished", fn, 0);
    tick();
    chk("fault sticky", outs(), 5'b00001);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort idle keeps fault", outs(), 5'b00001);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("fault cleared by reset", outs(), 0);
    tick();

    // randomized sequences with ignored-input noise
    for (int i = 0; i < 25; i++) begin
      n  = $urandom_range(0, 15);
      d  = $urandom_range(0, TO + 2);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 60) : 0;
      run_seq(n, d, ab, 1'b1, -1, st, fn, fk, ik, fl);
      timer_done = ($urandom_range(0, 1) == 1);
      tick();
      chk($sformatf("rand%0d gap idle", i), {timer_start, blank, busy, finished}, 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
